pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/cpu_pkg.sv | 14 +
 rtl/pc_fetch_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths and the fetch FSM state type.
package cpu_pkg;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register plus single-outstanding instruction fetch with a one-entry decode buffer.
// Define FETCH_PERF_CNT_EN to add saturating fetch_cnt/flush_cnt counters.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0] PC_STEP  = 16'd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    next_pc,
  output logic [PC_W-1:0]    pc_seq,
  input  logic               flush,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q;

  assign imem_addr = pc_q;
  assign pc_seq    = pc_q + PC_STEP;
  // Gated by reset so no request escapes while the unit is held in reset.
  assign imem_req  = (state_q == FETCH) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (flush) begin
            pc_q <= next_pc;
            // A grant coinciding with flush still yields a response that must be swallowed.
            if (imem_gnt) state_q <= KILL;
          end else if (imem_gnt) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            pc_q    <= next_pc;
            state_q <= imem_rvalid ? FETCH : KILL;
          end else if (imem_rvalid) begin
            if_instr <= imem_rdata;
            if_pc    <= pc_q;
            if_valid <= 1'b1;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          if (flush || if_ready) begin
            pc_q     <= next_pc;
            if_valid <= 1'b0;
            state_q  <= FETCH;
          end
        end
        KILL: begin
          if (flush) pc_q <= next_pc;
          if (imem_rvalid) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (if_valid && if_ready && (fetch_cnt != 16'hFFFF)) fetch_cnt <= fetch_cnt + 16'd1;
      if (flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  // Counters not built in this configuration.
`endif

endmodule
